// File: rtl/freq_pkg.sv
// freq_pkg: shared state encoding and default parameters for freq_meter
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE,
        DONE
    } state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_PER_W       = 12;
    localparam int DEF_TIMEOUT     = 4095;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus rising-edge detector for an asynchronous input
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic s1, s2, s3, primed, armed;

    // armed only after a genuine low has passed through, so a level already high at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, s3, primed, armed} <= '0;
        end else begin
            s1     <= d_async;
            s2     <= s1;
            s3     <= s2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~s1);
        end
    end

    assign q_sync = s2;
    assign rise   = armed & s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated edge count, high time and min/max period of an asynchronous signal
module freq_meter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PER_W       = DEF_PER_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [PER_W-1:0] per_min,
    output logic [PER_W-1:0] per_max,
    output logic             no_sig,
    output logic             ovf
);

    localparam int TMR_W = $clog2((GATE_CYCLES > TIMEOUT ? GATE_CYCLES : TIMEOUT) + 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] ecnt, hcnt;
    logic [PER_W-1:0] pcnt, pmin, pmax;
    logic             ovf_acc, timed_out, q_sync, rise;

    sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_async(sig_in),
        .q_sync (q_sync),
        .rise   (rise)
    );

    // measurement FSM; working counters run in MEASURE, results are published only from DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            ecnt      <= '0;
            hcnt      <= '0;
            pcnt      <= '0;
            pmin      <= '0;
            pmax      <= '0;
            ovf_acc   <= 1'b0;
            timed_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            edge_cnt  <= '0;
            high_cnt  <= '0;
            per_min   <= '0;
            per_max   <= '0;
            no_sig    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_EDGE;
                        busy      <= 1'b1;
                        tmr       <= '0;
                        ecnt      <= '0;
                        hcnt      <= '0;
                        pmin      <= '1;
                        pmax      <= '0;
                        ovf_acc   <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state <= MEASURE;
                        tmr   <= '0;
                        pcnt  <= PER_W'(1);
                    end else if (tmr == WAIT_LAST) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (q_sync) begin
                        if (&hcnt) ovf_acc <= 1'b1;
                        else       hcnt    <= hcnt + CNT_W'(1);
                    end
                    if (rise) begin
                        if (&ecnt) ovf_acc <= 1'b1;
                        else       ecnt    <= ecnt + CNT_W'(1);
                        pmin <= (pcnt < pmin) ? pcnt : pmin;
                        pmax <= (pcnt > pmax) ? pcnt : pmax;
                        pcnt <= PER_W'(1);
                    end else if (&pcnt) begin
                        ovf_acc <= 1'b1;
                    end else begin
                        pcnt <= pcnt + PER_W'(1);
                    end
                    if (tmr == GATE_LAST) state <= DONE;
                    else                  tmr   <= tmr + TMR_W'(1);
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    edge_cnt <= ecnt;
                    high_cnt <= hcnt;
                    per_min  <= (ecnt == '0) ? '0 : pmin;
                    per_max  <= pmax;
                    no_sig   <= timed_out;
                    ovf      <= ovf_acc;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: event-list model of freq_meter checked every cycle, plus directed literal checks
module tb_freq_meter;

    localparam int G    = 100;
    localparam int CW   = 6;
    localparam int PW   = 4;
    localparam int TO   = 50;
    localparam int NS   = 16384;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 0, rst_n = 0, sig_in = 0, start = 0;
    logic busy, done, no_sig, ovf;
    logic [CW-1:0] edge_cnt, high_cnt;
    logic [PW-1:0] per_min, per_max;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

    bit sig_s [NS];
    bit st_s  [NS];
    int rel = 0, acc = 0, ref_e = -1;
    bit active = 0;
    int e_edge = 0, e_high = 0, e_min = 0, e_max = 0;
    bit e_busy = 0, e_done = 0, e_nosig = 0, e_ovf = 0;

    int h0 = 1, l0 = 1, h1 = 1, l1 = 1, k = 0;
    bit pat_on = 0, pat_restart = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .PER_W(PW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .busy(busy), .done(done), .edge_cnt(edge_cnt), .high_cnt(high_cnt),
        .per_min(per_min), .per_max(per_max), .no_sig(no_sig), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // waveform generator: repeating high/low/high/low durations, changed 2 ns after each clk edge
    always begin
        @(posedge clk);
        #2;
        if (!pat_on) begin
            sig_in = 0;
            k = 0;
        end else begin
            if (pat_restart) begin
                k = 0;
                pat_restart = 0;
            end
            sig_in = (k < h0) || (k >= h0 + l0 && k < h0 + l0 + h1);
            k = (k + 1) % (h0 + l0 + h1 + l1);
        end
    end

    // an edge event is seen at clk edge n when the input rose between samples n-3 and n-2 after reset release
    function automatic bit ev(int n);
        return n >= 3 && n - 3 >= rel && sig_s[n-2] && !sig_s[n-3];
    endfunction

    // model and compare: at each falling edge, after rising edge c
    always @(negedge clk) begin
        int c, lst, p, d;
        c = cyc;
        if (c + 1 < NS) begin
            sig_s[c+1] = sig_in;
            st_s[c+1]  = start;
        end
        if (!rst_n) begin
            rel = c + 2;
            active = 0;
            {e_busy, e_done, e_nosig, e_ovf} = '0;
            e_edge = 0; e_high = 0; e_min = 0; e_max = 0;
        end else begin
            e_done = 0;
            if (active && ref_e < 0 && c > acc && c <= acc + TO && ev(c)) ref_e = c;
            d = ref_e >= 0 ? ref_e + G + 1 : (c >= acc + TO ? acc + TO + 1 : NS);
            if (active && c == d) begin
                active = 0; e_done = 1;
                e_edge = 0; e_high = 0; e_min = PMAX; e_max = 0; e_ovf = 0;
                e_nosig = ref_e < 0;
                if (ref_e >= 0) begin
                    lst = ref_e;
                    for (int n = ref_e + 1; n <= ref_e + G; n++) begin
                        if (sig_s[n-2]) begin
                            if (e_high == CMAX) e_ovf = 1; else e_high++;
                        end
                        if (ev(n)) begin
                            p = n - lst > PMAX ? PMAX : n - lst;
                            if (e_edge == CMAX) e_ovf = 1; else e_edge++;
                            if (p < e_min) e_min = p;
                            if (p > e_max) e_max = p;
                            lst = n;
                        end else if (n - lst >= PMAX) begin
                            e_ovf = 1;
                        end
                    end
                end
                if (e_edge == 0) e_min = 0;
            end else if (!active && st_s[c] && c >= rel) begin
                active = 1; acc = c; ref_e = -1;
            end
            e_busy = active;
        end
        checks++;
        if ({busy, done, edge_cnt, high_cnt, per_min, per_max, no_sig, ovf} !==
            {e_busy, e_done, CW'(e_edge), CW'(e_high), PW'(e_min), PW'(e_max), e_nosig, e_ovf}) begin
            errors++;
            $display("FAIL cycle %0d outputs: got busy=%0d done=%0d edge=%0d high=%0d min=%0d max=%0d no_sig=%0d ovf=%0d, expected busy=%0d done=%0d edge=%0d high=%0d min=%0d max=%0d no_sig=%0d ovf=%0d",
                     c, busy, done, edge_cnt, high_cnt, per_min, per_max, no_sig, ovf,
                     e_busy, e_done, e_edge, e_high, e_min, e_max, e_nosig, e_ovf);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_pat(int a, int b, int c, int d);
        pat_on = 0;
        tick(3);
        h0 = a; l0 = b; h1 = c; l1 = d;
        pat_restart = 1;
        pat_on = 1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 400) begin
            tick(1);
            n++;
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done within %0d cycles expected a done pulse", n);
        end
    endtask

    initial begin
        int n, d0;
        tick(4);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_edge", edge_cnt, 0);
        chk("rst_per_min", per_min, 0);
        rst_n = 1;
        tick(5);

        pulse_start();
        wait_done(n);
        chk("timeout_latency", n, 51);
        chk("timeout_no_sig", no_sig, 1);
        chk("timeout_edge", edge_cnt, 0);
        tick(3);

        pulse_start();
        tick(50);
        start = 1;
        tick(1);
        start = 0;
        chk("start_at_done_done", done, 1);
        tick(1);
        chk("start_at_done_busy", busy, 0);
        tick(3);
        chk("start_at_done_busy_later", busy, 0);

        set_pat(2, 3, 3, 2);
        tick(10);
        pulse_start();
        wait_done(n);
        chk("p5_edge", edge_cnt, 20);
        chk("p5_min", per_min, 5);
        chk("p5_max", per_max, 5);
        chk("p5_high_near_50", int'(high_cnt >= 49 && high_cnt <= 51), 1);
        chk("p5_no_sig", no_sig, 0);
        chk("p5_ovf", ovf, 0);

        set_pat(1, 1, 1, 2);
        tick(10);
        pulse_start();
        wait_done(n);
        chk("p25_edge", edge_cnt, 40);
        chk("p25_min", per_min, 2);
        chk("p25_max", per_max, 3);

        set_pat(2, 3, 3, 2);
        tick(10);
        d0 = done_cnt;
        pulse_start();
        tick(40);
        start = 1;
        tick(1);
        start = 0;
        wait_done(n);
        chk("dbl_start_edge", edge_cnt, 20);
        chk("dbl_start_min", per_min, 5);
        chk("dbl_start_max", per_max, 5);
        tick(150);
        chk("dbl_start_done_count", done_cnt - d0, 1);

        set_pat(10, 10, 10, 10);
        tick(5);
        pulse_start();
        wait_done(n);
        chk("p20_edge", edge_cnt, 5);
        chk("p20_max_sat", per_max, 15);
        chk("p20_min_sat", per_min, 15);
        chk("p20_ovf", ovf, 1);

        set_pat(18, 2, 18, 2);
        tick(5);
        pulse_start();
        wait_done(n);
        chk("hi_high_sat", high_cnt, 63);
        chk("hi_ovf", ovf, 1);

        set_pat(2, 3, 3, 2);
        tick(5);
        d0 = done_cnt;
        pulse_start();
        tick(35);
        rst_n = 0;
        tick(1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_high", high_cnt, 0);
        chk("mid_rst_ovf", ovf, 0);
        tick(2);
        rst_n = 1;
        tick(150);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        pulse_start();
        wait_done(n);
        chk("after_rst_edge", edge_cnt, 20);
        chk("after_rst_min", per_min, 5);

        set_pat(3, 400, 3, 400);
        pulse_start();
        wait_done(n);
        chk("single_edge_edge", edge_cnt, 0);
        chk("single_edge_min", per_min, 0);
        chk("single_edge_max", per_max, 0);
        chk("single_edge_no_sig", no_sig, 0);

        set_pat(1, 0, 1, 0);
        tick(5);
        rst_n = 0;
        tick(2);
        rst_n = 1;
        start = 1;
        tick(1);
        start = 0;
        pat_on = 0;
        tick(6);
        set_pat(2, 3, 3, 2);
        wait_done(n);
        chk("high_at_release_edge", edge_cnt, 20);
        chk("high_at_release_min", per_min, 5);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
